// File: rtl/clock_gen2_pkg.sv
// Shared types and helpers for clock_core_gen2: FSM state encoding, 7-segment table,
// blank digit code and BCD helpers for counting and 12 h display mapping.
package clock_gen2_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_AH   = 3'd3,
        ST_SET_AM   = 3'd4
    } state_t;

    localparam logic [3:0] BLANK = 4'hF;

    // Segment order is gfedcba, active high; index is the decimal digit.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return SEG_TABLE[digit];
        end
        return 7'h00;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] max_value);
        if (value == max_value) begin
            return 8'h00;
        end
        if (value[3:0] == 4'd9) begin
            return {value[7:4] + 4'd1, 4'd0};
        end
        return {value[7:4], value[3:0] + 4'd1};
    endfunction

    // 24 h BCD hour to 12 h BCD hour: 0 -> 12, 13..23 -> 1..11.
    function automatic logic [7:0] hour12_bcd(input logic [7:0] hour);
        logic [4:0] bin;
        bin = 5'(hour[7:4]) * 5'd10 + 5'(hour[3:0]);
        if (bin == 5'd0) begin
            bin = 5'd12;
        end else if (bin > 5'd12) begin
            bin = bin - 5'd12;
        end
        if (bin >= 5'd10) begin
            return {4'd1, 4'(bin - 5'd10)};
        end
        return {4'd0, 4'(bin)};
    endfunction

endpackage

// File: rtl/clock_core_gen2_btn_sync_edge.sv
// Button conditioner: two-flop synchroniser followed by a rising-edge detector that
// emits a single-cycle pulse per press, however long the button is held.
module btn_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    output logic pulse
);

    logic sync0_q, sync0_d;
    logic sync1_q, sync1_d;
    logic prev_q, prev_d;

    always_comb begin
        sync0_d = btn_in;
        sync1_d = sync0_q;
        prev_d  = sync1_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            prev_q  <= prev_d;
        end
    end

    assign pulse = sync1_q & ~prev_q;

endmodule

// File: rtl/clock_core_gen2.sv
// HH:MM:SS BCD clock with button set-mode FSM and 4-digit 7-segment HH:MM display.
// Optional alarm (SET_AH/SET_AM states, alarm output) is built when CLOCK_ALARM_EN is defined.
module clock_core_gen2
    import clock_gen2_pkg::*;
#(
    parameter int TICKS_PER_SEC  = 50000000,
    parameter int HOUR_12        = 0,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        advance_btn,
    input  logic        increment_btn,
    output logic [7:0]  hour_bcd,
    output logic [7:0]  min_bcd,
    output logic [7:0]  sec_bcd,
    output logic [27:0] seg_out,
    output logic        dot,
    output logic        pm,
    output logic [2:0]  debug_state,
    output logic        alarm
);

    localparam int TW = $clog2(TICKS_PER_SEC);
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_SEC / 2);

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [7:0]    hour_q, hour_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic          adv_pulse, inc_pulse, time_tick;

`ifdef CLOCK_ALARM_EN
    logic [7:0]    alarm_hour_q, alarm_hour_d;
    logic [7:0]    alarm_min_q, alarm_min_d;
    logic          alarm_q, alarm_d;
`endif

    logic [7:0]    disp_hour, disp_min, hour_12h;
    logic [3:0]    dig3, dig2, dig1, dig0;
    logic [27:0]   seg_raw;
    logic          half_phase, sel_hour, sel_min;

    btn_sync_edge u_adv_sync (
        .clock  (clock),
        .reset  (reset),
        .btn_in (advance_btn),
        .pulse  (adv_pulse)
    );

    btn_sync_edge u_inc_sync (
        .clock  (clock),
        .reset  (reset),
        .btn_in (increment_btn),
        .pulse  (inc_pulse)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            tick_q  <= '0;
            hour_q  <= 8'h00;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
`ifdef CLOCK_ALARM_EN
            alarm_hour_q <= 8'h00;
            alarm_min_q  <= 8'h00;
            alarm_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
`ifdef CLOCK_ALARM_EN
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            alarm_q      <= alarm_d;
`endif
        end
    end

    // Advance has priority: it restarts the prescaler and swallows any same-cycle increment.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        time_tick = 1'b0;
`ifdef CLOCK_ALARM_EN
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        alarm_d      = alarm_q;
`endif
        if (adv_pulse) begin
            tick_d = '0;
            case (state_q)
                ST_RUN:      state_d = ST_SET_HOUR;
                ST_SET_HOUR: state_d = ST_SET_MIN;
                ST_SET_MIN: begin
                    sec_d = 8'h00;
`ifdef CLOCK_ALARM_EN
                    state_d = ST_SET_AH;
`else
                    state_d = ST_RUN;
`endif
                end
`ifdef CLOCK_ALARM_EN
                ST_SET_AH:   state_d = ST_SET_AM;
`endif
                default:     state_d = ST_RUN;
            endcase
        end else begin
            tick_d    = (tick_q == TICK_MAX) ? '0 : tick_q + TW'(1);
            time_tick = (state_q == ST_RUN) && (tick_q == TICK_MAX);
            if (time_tick) begin
                sec_d = bcd_inc(sec_q, 8'h59);
                if (sec_q == 8'h59) begin
                    min_d = bcd_inc(min_q, 8'h59);
                    if (min_q == 8'h59) begin
                        hour_d = bcd_inc(hour_q, 8'h23);
                    end
                end
            end else if (inc_pulse) begin
                case (state_q)
                    ST_SET_HOUR: hour_d = bcd_inc(hour_q, 8'h23);
                    ST_SET_MIN:  min_d  = bcd_inc(min_q, 8'h59);
`ifdef CLOCK_ALARM_EN
                    ST_SET_AH:   alarm_hour_d = bcd_inc(alarm_hour_q, 8'h23);
                    ST_SET_AM:   alarm_min_d  = bcd_inc(alarm_min_q, 8'h59);
`endif
                    default: ;
                endcase
            end
        end
`ifdef CLOCK_ALARM_EN
        // Rises only on the second tick that lands on HH:MM:00, so an acknowledge sticks.
        if (adv_pulse || inc_pulse) begin
            alarm_d = 1'b0;
        end else if (time_tick && hour_d == alarm_hour_q && min_d == alarm_min_q && sec_d == 8'h00) begin
            alarm_d = 1'b1;
        end else if (min_d != min_q) begin
            alarm_d = 1'b0;
        end
`endif
    end

    always_comb begin
        disp_hour  = hour_q;
        disp_min   = min_q;
        half_phase = (tick_q >= TICK_HALF);
        sel_hour   = (state_q == ST_SET_HOUR);
        sel_min    = (state_q == ST_SET_MIN);
`ifdef CLOCK_ALARM_EN
        if (state_q == ST_SET_AH || state_q == ST_SET_AM) begin
            disp_hour = alarm_hour_q;
            disp_min  = alarm_min_q;
        end
        sel_hour = sel_hour || (state_q == ST_SET_AH);
        sel_min  = sel_min || (state_q == ST_SET_AM);
`endif
        hour_12h = hour12_bcd(disp_hour);
        if (HOUR_12 != 0) begin
            dig3 = (hour_12h[7:4] == 4'd0) ? BLANK : hour_12h[7:4];
            dig2 = hour_12h[3:0];
        end else begin
            dig3 = disp_hour[7:4];
            dig2 = disp_hour[3:0];
        end
        dig1 = disp_min[7:4];
        dig0 = disp_min[3:0];
        if (half_phase && sel_hour) begin
            dig3 = BLANK;
            dig2 = BLANK;
        end
        if (half_phase && sel_min) begin
            dig1 = BLANK;
            dig0 = BLANK;
        end
        seg_raw = {seg_decode(dig3), seg_decode(dig2), seg_decode(dig1), seg_decode(dig0)};
        seg_out = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        dot     = (state_q != ST_RUN) || !half_phase;
    end

    assign hour_bcd    = hour_q;
    assign min_bcd     = min_q;
    assign sec_bcd     = sec_q;
    assign pm          = (HOUR_12 != 0) && (hour_q >= 8'h12);
    assign debug_state = state_q;
`ifdef CLOCK_ALARM_EN
    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_clock_core_gen2.sv
// Directed self-checking bench for clock_core_gen2 with TICKS_PER_SEC=4: one 24 h
// active-low instance and one 12 h active-high instance share the same button stimulus.
module tb_clock_core_gen2;

`ifdef CLOCK_ALARM_EN
    localparam logic [31:0] ALARM_ON = 32'd1;
`else
    localparam logic [31:0] ALARM_ON = 32'd0;
`endif

    logic        clock;
    logic        reset;
    logic        advance_btn;
    logic        increment_btn;

    logic [7:0]  hour24, min24, sec24;
    logic [27:0] seg24;
    logic        dot24, pm24, alarm24;
    logic [2:0]  state24;

    logic [7:0]  hour12, min12, sec12;
    logic [27:0] seg12;
    logic        dot12, pm12, alarm12;
    logic [2:0]  state12;

    int checkCount = 0;
    int errorCount = 0;

    clock_core_gen2 #(.TICKS_PER_SEC(4), .HOUR_12(0), .SEG_ACTIVE_LOW(1)) dut24 (
        .clock         (clock),
        .reset         (reset),
        .advance_btn   (advance_btn),
        .increment_btn (increment_btn),
        .hour_bcd      (hour24),
        .min_bcd       (min24),
        .sec_bcd       (sec24),
        .seg_out       (seg24),
        .dot           (dot24),
        .pm            (pm24),
        .debug_state   (state24),
        .alarm         (alarm24)
    );

    clock_core_gen2 #(.TICKS_PER_SEC(4), .HOUR_12(1), .SEG_ACTIVE_LOW(0)) dut12 (
        .clock         (clock),
        .reset         (reset),
        .advance_btn   (advance_btn),
        .increment_btn (increment_btn),
        .hour_bcd      (hour12),
        .min_bcd       (min12),
        .sec_bcd       (sec12),
        .seg_out       (seg12),
        .dot           (dot12),
        .pm            (pm12),
        .debug_state   (state12),
        .alarm         (alarm12)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Each press: held 3 cycles (pulse acted on by the 3rd edge), then released 2 cycles.
    task automatic applyStimulus(input logic adv, input logic inc, input int n);
        for (int i = 0; i < n; i++) begin
            advance_btn   = adv;
            increment_btn = inc;
            waitCycles(3);
            advance_btn   = 1'b0;
            increment_btn = 1'b0;
            waitCycles(2);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        advance_btn   = 1'b0;
        increment_btn = 1'b0;
        waitCycles(2);
        reset = 1'b0;

        checkOutput("rst_hour", hour24, 8'h00);
        checkOutput("rst_min", min24, 8'h00);
        checkOutput("rst_sec", sec24, 8'h00);
        checkOutput("rst_seg24", seg24, {7'h40, 7'h40, 7'h40, 7'h40});
        checkOutput("rst_seg12", seg12, {7'h06, 7'h5B, 7'h3F, 7'h3F});
        checkOutput("rst_state", state24, 3'd0);
        checkOutput("rst_dot", dot24, 1'b1);
        checkOutput("rst_pm12", pm12, 1'b0);
        checkOutput("rst_alarm", alarm24, 1'b0);

        for (int k = 1; k <= 8; k++) begin
            waitCycles(1);
            checkOutput("dot_run", dot24, ((k % 4) < 2) ? 32'd1 : 32'd0);
        end
        waitCycles(231);
        checkOutput("t239_sec", sec24, 8'h59);
        checkOutput("t239_min", min24, 8'h00);
        waitCycles(1);
        checkOutput("t240_min", min24, 8'h01);
        checkOutput("t240_sec", sec24, 8'h00);
        waitCycles(20);
        checkOutput("t260_sec", sec24, 8'h05);

        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("sethr_state", state24, 3'd1);
        checkOutput("sethr_blink24", seg24, {7'h7F, 7'h7F, 7'h40, 7'h79});
        checkOutput("sethr_blink12", seg12, {7'h00, 7'h00, 7'h3F, 7'h06});
        checkOutput("sethr_dot", dot24, 1'b1);
        waitCycles(2);
        checkOutput("sethr_show24", seg24, {7'h40, 7'h40, 7'h40, 7'h79});

        applyStimulus(1'b0, 1'b1, 23);
        checkOutput("inc_hr23", hour24, 8'h23);
        checkOutput("inc_pm23", pm12, 1'b1);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("inc_hr_wrap", hour24, 8'h00);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("inc_hr01", hour24, 8'h01);
        checkOutput("inc_hr_min", min24, 8'h01);
        checkOutput("frozen_sec", sec24, 8'h05);

        applyStimulus(1'b0, 1'b1, 22);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("setmin_state", state24, 3'd2);
        checkOutput("setmin_hr", hour24, 8'h23);
        applyStimulus(1'b0, 1'b1, 58);
        checkOutput("inc_min59", min24, 8'h59);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("inc_min_wrap", min24, 8'h00);
        checkOutput("inc_min_nocarry", hour24, 8'h23);
        applyStimulus(1'b0, 1'b1, 59);
        checkOutput("inc_min59b", min24, 8'h59);

        applyStimulus(1'b1, 1'b1, 1);
`ifdef CLOCK_ALARM_EN
        checkOutput("both_state", state24, 3'd3);
        applyStimulus(1'b1, 1'b0, 2);
`endif
        checkOutput("both_run", state24, 3'd0);
        checkOutput("both_min", min24, 8'h59);
        checkOutput("both_sec", sec24, 8'h00);

        waitCycles(234);
        checkOutput("pre_hour", hour24, 8'h23);
        checkOutput("pre_min", min24, 8'h59);
        checkOutput("pre_sec", sec24, 8'h59);
        checkOutput("pre_seg12", seg12, {7'h06, 7'h06, 7'h6D, 7'h6F});
        waitCycles(4);
        checkOutput("roll_hour", hour24, 8'h00);
        checkOutput("roll_min", min24, 8'h00);
        checkOutput("roll_sec", sec24, 8'h00);
        checkOutput("roll_pm12", pm12, 1'b0);
        checkOutput("roll_seg24", seg24, {7'h40, 7'h40, 7'h40, 7'h40});

        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 13);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b0, 1);
`ifdef CLOCK_ALARM_EN
        checkOutput("setah_state", state24, 3'd3);
        checkOutput("setah_seg24", seg24, {7'h7F, 7'h7F, 7'h40, 7'h40});
        applyStimulus(1'b0, 1'b1, 13);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 6);
        applyStimulus(1'b1, 1'b0, 1);
`endif
        checkOutput("h12_state", state24, 3'd0);
        checkOutput("h12_hour", hour12, 8'h13);
        checkOutput("h12_min", min24, 8'h05);
        checkOutput("h12_seg12", seg12, {7'h00, 7'h06, 7'h3F, 7'h6D});
        checkOutput("h12_pm12", pm12, 1'b1);
        checkOutput("h12_pm24", pm24, 1'b0);
        checkOutput("h12_seg24", seg24, {7'h79, 7'h30, 7'h40, 7'h12});

        waitCycles(237);
        checkOutput("al_pre_sec", sec24, 8'h59);
        checkOutput("al_pre", alarm24, 1'b0);
        waitCycles(1);
        checkOutput("al_min", min24, 8'h06);
        checkOutput("al_rise24", alarm24, ALARM_ON);
        checkOutput("al_rise12", alarm12, ALARM_ON);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("al_ack", alarm24, 1'b0);
        checkOutput("al_ack_min", min24, 8'h06);
        checkOutput("al_ack_sec", sec12, 8'h01);
        checkOutput("al_dot12", dot12, 1'b1);
        checkOutput("al_state12", state12, 3'd0);
        checkOutput("al_min12", min12, 8'h06);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
